// File: rtl/pow_pkg.sv
// Shared types and widths for the proof-of-work nonce scheduler.
package pow_pkg;

  localparam int DIGEST_W = 256;
  localparam int NONCE_W  = 64;
  localparam int PROOF_W  = 32;
  localparam int DIFF_W   = 8;

  typedef logic [NONCE_W-1:0] nonce_t;

  // state | meaning
  // IDLE  | no search in progress, waiting for start
  // ISSUE | padded block stable, waiting for sha_ready to pulse sha_start
  // WAIT  | hash outstanding, waiting for sha_done
  // CHECK | evaluate registered digest against difficulty
  // DONE  | search finished (hit or exhausted), results held
  // DRAIN | aborted with a hash outstanding, swallow its sha_done
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4,
    DRAIN = 3'd5
  } state_t;

endpackage

// File: rtl/pow_lz_check.sv
// Leading-zero check: hit when the top 'difficulty' bits of the digest are all zero.
module pow_lz_check
  import pow_pkg::*;
(
  input  logic [DIGEST_W-1:0] digest,
  input  logic [DIFF_W-1:0]   difficulty,
  output logic                hit
);

  logic [DIGEST_W-1:0] mask;

  // Mask covers the 'difficulty' most significant bits; difficulty 0 gives an empty mask.
  always_comb begin
    mask = ~({DIGEST_W{1'b1}} >> difficulty);
    hit  = ((digest & mask) == '0);
  end

endmodule

// File: rtl/pow_nonce_scheduler.sv
// Proof-of-work nonce search sequencer: one SHA-256 compression per nonce.
module pow_nonce_scheduler
  import pow_pkg::*;
#(
  parameter nonce_t MAX_NONCE = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [PROOF_W-1:0]  last_proof,
  input  logic [DIFF_W-1:0]   difficulty,
  output logic [PROOF_W-1:0]  pad_last_proof,
  output logic [NONCE_W-1:0]  pad_nonce,
  input  logic                sha_ready,
  output logic                sha_start,
  input  logic                sha_done,
  input  logic [DIGEST_W-1:0] sha_digest,
  output logic                busy,
  output logic                found,
  output logic                exhausted,
  output logic [NONCE_W-1:0]  result_nonce,
  output logic [NONCE_W-1:0]  attempts
);

  state_t              state, state_nxt;
  logic [PROOF_W-1:0]  proof_q;
  logic [DIFF_W-1:0]   diff_q;
  nonce_t              nonce_q;
  nonce_t              attempts_q;
  nonce_t              result_q;
  logic                found_q;
  logic                exh_q;
  logic [DIGEST_W-1:0] digest_q;
  logic                hit;
  logic                start_ok;
  logic                at_max;

  pow_lz_check u_lz (
    .digest     (digest_q),
    .difficulty (diff_q),
    .hit        (hit)
  );

  // abort wins over a coincident start, so start is only taken when abort is low
  assign start_ok = start && !abort && ((state == IDLE) || (state == DONE));
  assign at_max   = (nonce_q == MAX_NONCE);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start_ok) state_nxt = ISSUE;
      ISSUE: begin
        if (abort)          state_nxt = IDLE;
        else if (sha_ready) state_nxt = WAIT;
      end
      WAIT: begin
        // an abort coinciding with sha_done has nothing left to drain
        if (abort)         state_nxt = sha_done ? IDLE : DRAIN;
        else if (sha_done) state_nxt = CHECK;
      end
      CHECK: begin
        if (abort)       state_nxt = IDLE;
        else if (hit)    state_nxt = DONE;
        else if (at_max) state_nxt = DONE;
        else             state_nxt = ISSUE;
      end
      DONE:  if (start_ok) state_nxt = ISSUE;
      DRAIN: if (sha_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state; sha_start drops as soon as reset forces IDLE
  always_comb begin
    busy      = (state != IDLE) && (state != DONE);
    sha_start = (state == ISSUE) && sha_ready && !abort;
  end

  // Search datapath: latched inputs, nonce, digest and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      proof_q    <= '0;
      diff_q     <= '0;
      nonce_q    <= '0;
      attempts_q <= '0;
      result_q   <= '0;
      found_q    <= 1'b0;
      exh_q      <= 1'b0;
      digest_q   <= '0;
    end else begin
      if (start_ok) begin
        proof_q    <= last_proof;
        diff_q     <= difficulty;
        nonce_q    <= '0;
        attempts_q <= '0;
        result_q   <= '0;
        found_q    <= 1'b0;
        exh_q      <= 1'b0;
      end
      if ((state == WAIT) && sha_done) digest_q <= sha_digest;
      if ((state == CHECK) && !abort) begin
        attempts_q <= attempts_q + 1'b1;
        if (hit) begin
          found_q  <= 1'b1;
          result_q <= nonce_q;
        end else if (at_max) begin
          exh_q <= 1'b1;
        end else begin
          nonce_q <= nonce_q + 1'b1;
        end
      end
    end
  end

  assign pad_last_proof = proof_q;
  assign pad_nonce      = nonce_q;
  assign found          = found_q;
  assign exhausted      = exh_q;
  assign result_nonce   = result_q;
  assign attempts       = attempts_q;

endmodule
